// File: rtl/tx_scheduler.sv
// Two-requester round-robin transmit scheduler for the ASK/FSK transmitter.
// Times each frame internally and inserts a guard gap between frames.
module tx_scheduler #(
    parameter int MSG_W      = 5,
    parameter int CNT_W      = 3,
    parameter int BIT_CYCLES = 100,
    parameter int GAP_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [MSG_W-1:0] req0_msg,
    input  logic             req0_mode,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [MSG_W-1:0] req1_msg,
    input  logic             req1_mode,
    input  logic [CNT_W-1:0] req1_cnt,
    output logic             send,
    output logic [MSG_W-1:0] msg,
    output logic             mode,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             grant_id,
    output logic             frame_done
);

    localparam int F  = MSG_W * BIT_CYCLES;
    localparam int FW = (F > 1) ? $clog2(F) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic               send_q, send_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               grant_id_q, grant_id_d;
    logic               last_grant_q, last_grant_d;
    logic               any_valid;
    logic               grant_sel;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        any_valid  = req0_valid | req1_valid;
        grant_sel  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = (state_q == IDLE) && any_valid && !grant_sel;
        req1_ready = (state_q == IDLE) && any_valid && grant_sel;
    end

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        send_d       = send_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        msg_d        = msg_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d      = SEND;
                    send_d       = 1'b1;
                    busy_d       = 1'b1;
                    frame_cnt_d  = '0;
                    frame_done_d = (F == 1);
                    grant_id_d   = grant_sel;
                    last_grant_d = grant_sel;
                    msg_d        = grant_sel ? req1_msg  : req0_msg;
                    mode_d       = grant_sel ? req1_mode : req0_mode;
                    cnt_d        = grant_sel ? req1_cnt  : req0_cnt;
                end
            end
            SEND: begin
                if (frame_cnt_q == FW'(F - 1)) begin
                    state_d   = GAP;
                    send_d    = 1'b0;
                    gap_cnt_d = '0;
                end else begin
                    frame_cnt_d  = frame_cnt_q + FW'(1);
                    frame_done_d = (frame_cnt_q == FW'(F - 2));
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                send_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            send_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            msg_q        <= '0;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
            grant_id_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            send_q       <= send_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            msg_q        <= msg_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign send       = send_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign msg        = msg_q;
    assign mode       = mode_q;
    assign cnt        = cnt_q;
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: arbitration table, frame scoreboard
// and hand-written reset / contention / withdrawn-request sequences.
module tb_tx_scheduler;

    localparam int MSG_W = 5;
    localparam int CNT_W = 3;
    localparam int BITC  = 10;
    localparam int GAPC  = 4;
    localparam int F     = MSG_W * BITC;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [MSG_W-1:0] req0_msg, req1_msg;
    logic             req0_mode, req1_mode;
    logic [CNT_W-1:0] req0_cnt, req1_cnt;
    logic             send, busy, grant_id, frame_done, mode;
    logic [MSG_W-1:0] msg;
    logic [CNT_W-1:0] cnt;

    tx_scheduler #(
        .MSG_W(MSG_W), .CNT_W(CNT_W),
        .BIT_CYCLES(BITC), .GAP_CYCLES(GAPC)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_msg(req0_msg), .req0_mode(req0_mode), .req0_cnt(req0_cnt),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_msg(req1_msg), .req1_mode(req1_mode), .req1_cnt(req1_cnt),
        .send(send), .msg(msg), .mode(mode), .cnt(cnt),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [MSG_W-1:0] msg;
        logic             mode;
        logic [CNT_W-1:0] cnt;
    } frame_t;

    typedef struct {
        logic             v0, v1;
        logic [MSG_W-1:0] m0, m1;
        logic             md0, md1;
        logic [CNT_W-1:0] c0, c1;
        logic             r0, r1;
    } vec_t;

    frame_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    logic   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v0, input logic v1,
                                input logic [MSG_W-1:0] m0, input logic md0,
                                input logic [CNT_W-1:0] c0,
                                input logic [MSG_W-1:0] m1, input logic md1,
                                input logic [CNT_W-1:0] c1,
                                input logic r0, input logic r1);
        vec_t v;
        v.v0 = v0; v.v1 = v1; v.m0 = m0; v.m1 = m1;
        v.md0 = md0; v.md1 = md1; v.c0 = c0; v.c1 = c1;
        v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    // Frame monitor: pops the expected frame at send rise, checks length,
    // frame_done position, payload stability and gap length.
    frame_t cur;
    logic   in_frame = 1'b0;
    logic   in_gap = 1'b0;
    int     len = 0;
    int     gap = 0;

    always @(negedge clk) begin
        if (!mon_en) begin
            in_frame = 1'b0;
            in_gap   = 1'b0;
            len      = 0;
            gap      = 0;
        end else if (send) begin
            if (!in_frame) begin
                chk("frame_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) cur = exp_q.pop_front();
                else cur = '{1'b0, '0, 1'b0, '0};
                in_frame = 1'b1;
                in_gap   = 1'b0;
                len      = 0;
            end
            len++;
            chk("send_msg", msg, cur.msg);
            chk("send_mode", mode, cur.mode);
            chk("send_cnt", cnt, cur.cnt);
            chk("send_gid", grant_id, cur.id);
            chk("send_busy", busy, 1);
            chk("frame_done_pos", frame_done, len == F);
        end else begin
            chk("frame_done_idle", frame_done, 0);
            if (in_frame) begin
                chk("frame_len", len, F);
                in_frame = 1'b0;
                in_gap   = 1'b1;
                gap      = 0;
            end
            if (in_gap) begin
                if (busy) begin
                    gap++;
                    chk("gap_msg_hold", msg, cur.msg);
                end else begin
                    chk("gap_len", gap, GAPC);
                    chk("idle_msg_hold", msg, cur.msg);
                    in_gap = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_send", send, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_msg", msg, 0);
        chk("rst_mode", mode, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_gid", grant_id, 0);
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic push(input logic id, input logic [MSG_W-1:0] m,
                        input logic md, input logic [CNT_W-1:0] c);
        frame_t f;
        f.id = id; f.msg = m; f.mode = md; f.cnt = c;
        exp_q.push_back(f);
    endtask

    vec_t vecs[8];

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1);
    end

    initial begin
        int r0n, r1n, n, cyc, prev;
        logic exp_id;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_msg = '0; req1_msg = '0;
        req0_mode = 1'b0; req1_mode = 1'b0;
        req0_cnt = '0; req1_cnt = '0;
        repeat (2) @(negedge clk);
        do_reset();

        // last_grant starts at 1, so ties alternate 1,0,... after vector 0.
        vecs[0] = mk(1, 0, 5'b11010, 0, 3'd0, 5'd0,     0, 3'd0, 1, 0);
        vecs[1] = mk(1, 1, 5'b10101, 0, 3'd2, 5'b00101, 1, 3'd5, 0, 1);
        vecs[2] = mk(1, 1, 5'b01110, 1, 3'd4, 5'b10001, 0, 3'd1, 1, 0);
        vecs[3] = mk(1, 1, 5'b00011, 0, 3'd6, 5'b11111, 1, 3'd3, 0, 1);
        vecs[4] = mk(0, 1, 5'b00000, 0, 3'd0, 5'b01010, 0, 3'd7, 0, 1);
        vecs[5] = mk(1, 1, 5'b11100, 1, 3'd1, 5'b00110, 1, 3'd2, 1, 0);
        vecs[6] = mk(0, 0, 5'b11111, 1, 3'd7, 5'b11111, 1, 3'd7, 0, 0);
        vecs[7] = mk(1, 0, 5'b00000, 1, 3'd7, 5'b10000, 0, 3'd0, 1, 0);

        for (int i = 0; i < 8; i++) begin
            wait_idle();
            req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
            req0_msg = vecs[i].m0; req1_msg = vecs[i].m1;
            req0_mode = vecs[i].md0; req1_mode = vecs[i].md1;
            req0_cnt = vecs[i].c0; req1_cnt = vecs[i].c1;
            #1;
            chk("tbl_ready0", req0_ready, vecs[i].r0);
            chk("tbl_ready1", req1_ready, vecs[i].r1);
            if (vecs[i].r0) push(1'b0, vecs[i].m0, vecs[i].md0, vecs[i].c0);
            if (vecs[i].r1) push(1'b1, vecs[i].m1, vecs[i].md1, vecs[i].c1);
            @(negedge clk);
            chk("tbl_send_start", send, vecs[i].r0 | vecs[i].r1);
            chk("tbl_busy_start", busy, vecs[i].r0 | vecs[i].r1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_msg = ~req0_msg; req1_msg = ~req1_msg;
            req0_mode = ~req0_mode; req1_mode = ~req1_mode;
            req0_cnt = ~req0_cnt; req1_cnt = ~req1_cnt;
        end
        wait_idle();

        // Contention from reset: both valid held for four frames.
        do_reset();
        req0_msg = 5'b11010; req0_mode = 1'b0; req0_cnt = 3'd1;
        req1_msg = 5'b00101; req1_mode = 1'b1; req1_cnt = 3'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_id = 1'b0;
        r0n = 0; r1n = 0; n = 0; prev = 0;
        for (cyc = 0; cyc < 400 && n < 4; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("cont_one_ready", req0_ready & req1_ready, 0);
                chk("cont_order", req1_ready, exp_id);
                if (req1_ready) push(1'b1, req1_msg, req1_mode, req1_cnt);
                else push(1'b0, req0_msg, req0_mode, req0_cnt);
                if (req0_ready) r0n++;
                if (req1_ready) r1n++;
                if (n > 0) chk("cont_spacing", cyc - prev, F + GAPC + 1);
                prev = cyc;
                exp_id = ~exp_id;
                n++;
            end
            @(negedge clk);
        end
        chk("cont_frames", n, 4);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_r0_pulses", r0n, 2);
        chk("cont_r1_pulses", r1n, 2);
        wait_idle();

        // Reset 20 cycles into a frame, then a tie must go to requester 0.
        req0_msg = 5'b10110; req0_mode = 1'b1; req0_cnt = 3'd5;
        req0_valid = 1'b1;
        #1;
        chk("mid_ready0", req0_ready, 1);
        push(1'b0, 5'b10110, 1'b1, 3'd5);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_send_before", send, 1);
        do_reset();
        req0_msg = 5'b01001; req0_mode = 1'b0; req0_cnt = 3'd3;
        req1_msg = 5'b11110; req1_mode = 1'b1; req1_cnt = 3'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("post_rst_r0", req0_ready, 1);
        chk("post_rst_r1", req1_ready, 0);
        push(1'b0, 5'b01001, 1'b0, 3'd3);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();

        // Requester 1 pulses valid only while busy: no extra frame.
        req0_msg = 5'b00111; req0_mode = 1'b0; req0_cnt = 3'd6;
        req0_valid = 1'b1;
        #1;
        push(1'b0, 5'b00111, 1'b0, 3'd6);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (10) @(negedge clk);
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("wd_ready1", req1_ready, 0);
            @(negedge clk);
        end
        req1_valid = 1'b0;
        wait_idle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k % 5 == 0) begin
                chk("wd_send", send, 0);
                chk("wd_busy", busy, 0);
            end
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Two-requester transmit scheduler that sits in front of the ASK/FSK transmitter top level. It accepts 5-bit messages and per-message modulation settings from two sources over valid/ready handshakes and arbitrates between them round-robin. It drives the transmitter's `send`, `msg`, `mode` and `cnt` inputs, holding them stable for exactly one frame and then inserting a guard gap. It times each frame itself, because the transmitter has no busy/done output.

## Interface
- `MSG_W`, 5, message width in bits; frame length is `MSG_W` bit periods.
- `CNT_W`, 3, width of the transmitter `cnt` setting.
- `BIT_CYCLES`, 100, clock cycles per transmitted bit, ≥1.
- `GAP_CYCLES`, 4, idle cycles with `send`=0 between frames, ≥1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req0_valid`  in  1  requester 0 has a message.
- `req0_ready`  out  1  requester 0 message accepted this cycle when `req0_valid` is also high.
- `req0_msg`  in  `MSG_W`  requester 0 payload.
- `req0_mode`  in  1  requester 0 modulation: 0=ASK, 1=FSK.
- `req0_cnt`  in  `CNT_W`  requester 0 transmitter count setting.
- `req1_valid`, `req1_ready`, `req1_msg`, `req1_mode`, `req1_cnt`: same as requester 0, for requester 1.
- `send`  out  1  transmitter enable; high for the whole frame.
- `msg`  out  `MSG_W`  latched payload to transmitter.
- `mode`  out  1  latched modulation select.
- `cnt`  out  `CNT_W`  latched count setting.
- `busy`  out  1  high in SEND and GAP.
- `grant_id`  out  1  requester owning the current or last frame.
- `frame_done`  out  1  one-cycle pulse on the last SEND cycle.

## Operation
- States: IDLE, SEND, GAP. Reset state is IDLE.
- Arbitration in IDLE is combinational:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- `reqN_ready` = (state==IDLE) && granted==N. Ready never asserts outside IDLE. Both readies are never high together.
- Handshake (`valid`&&`ready` at an edge):
  - Latch that requester's `msg`/`mode`/`cnt` into the outputs.
  - Set `grant_id` and `last_grant` to the granted requester.
  - Load the frame counter with 0 and go to SEND.
- SEND: `send`=1. Counter increments each cycle. At count = `MSG_W*BIT_CYCLES-1`: assert `frame_done`, load the gap counter, and go to GAP.
- GAP: `send`=0. After `GAP_CYCLES` cycles, go to IDLE.
- `msg`/`mode`/`cnt`/`grant_id` hold their values after the frame until the next handshake.
- Counter widths: frame counter is `$clog2(MSG_W*BIT_CYCLES)` bits, minimum 1. Gap counter is `$clog2(GAP_CYCLES+1)` bits. No wrap occurs; counters are reloaded per frame.
- Requester payload changes while not accepted are ignored. Changes after acceptance do not affect the frame in flight.
- Deasserting valid before a grant is legal and withdraws the request.

## Timing
- Reset values: `send`=0, `busy`=0, `frame_done`=0, `msg`=0, `mode`=0, `cnt`=0, `grant_id`=0, internal `last_grant`=1.
- Reset mid-frame: on the cycle after `rst` is sampled high, all outputs are at reset values and the state is IDLE. No partial frame resumes.
- Handshake at edge k:
  - `send`=1 and `busy`=1 from cycle k+1 through k+F, where F = `MSG_W*BIT_CYCLES`.
  - `frame_done`=1 only in cycle k+F.
  - GAP occupies cycles k+F+1 through k+F+`GAP_CYCLES`, with `busy`=1 and `send`=0.
  - IDLE at k+F+`GAP_CYCLES`+1; a new ready may assert in that same cycle.
- Minimum frame-start spacing is F+`GAP_CYCLES`+1 cycles.
- Outputs are registered, with no combinational path from requester inputs to `send`/`msg`/`mode`/`cnt`. Ready is combinational from state and valids.

## Test plan
Defaults: `BIT_CYCLES`=10, `GAP_CYCLES`=4, so F=50.
- Single request: `req0` with msg=11010, mode=0, cnt=0, valid at cycle 2 after reset. Expect `req0_ready`=1 at cycle 2, `send`=1 in cycles 3–52 with `msg`=11010 and `mode`=0, `frame_done` at cycle 52, `busy` low from cycle 57.
- Simultaneous first requests: `req0` msg=11010 and `req1` msg=00101/mode=1 both valid at cycle 2. Expect `req0` served first; `req1_ready` at cycle 57; second frame `send` in cycles 58–107 with `msg`=00101, `mode`=1, `grant_id`=1.
- Persistent contention: both valid continuously for 4 frames. Expect `grant_id` sequence 0,1,0,1 and each ready pulsing exactly twice.
- Reset mid-SEND: assert `rst` at cycle 20 of a frame. Expect `send`/`busy`/`msg` = 0 next cycle. After `rst` drops with both valid, `req0` is granted first.
- No request / withdrawn request: `req1_valid` pulsed only while busy, then dropped. Expect no extra frame; `send` stays 0 and state remains IDLE.
- Payload change during frame: change `req0_msg` after acceptance. Expect `msg` output unchanged until `frame_done` and through GAP.
